// File: rtl/load_scoreboard_pkg.sv
// rtl/load_scoreboard_pkg.sv - shared constants and helpers for the load scoreboard
// Counter range macro, guard-bit width and the max-pending helper.

`define SB_CNT_RANGE(w) [(w)-1:0]

package load_scoreboard_pkg;

  // Two extra bits hold inc minus up to a few clears without wrapping.
  localparam int SB_CNT_GUARD_W = 2;

  function automatic int sb_max_pending(input int pend_w);
    return (1 << pend_w) - 1;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - per-register outstanding-load counter
// Saturation-aware up/down counter with flush and underflow detection.

module sb_counter
  import load_scoreboard_pkg::*;
#(
  parameter int C_PEND_W    = 2,
  parameter int C_CLR_PORTS = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clk_en_i,
  input  logic                   inc_i,
  input  logic [C_CLR_PORTS-1:0] match_i,
  input  logic                   flush_i,
  output logic [C_PEND_W-1:0]    count_o,
  output logic                   nonzero_o,
  output logic                   saturated_o,
  output logic                   underflow_o
);

  localparam int NW = C_PEND_W + SB_CNT_GUARD_W;
  localparam logic [C_PEND_W-1:0] MAX_CNT = C_PEND_W'(sb_max_pending(C_PEND_W));

  logic `SB_CNT_RANGE(C_PEND_W) count_q, count_d;
  logic [NW-1:0]        dec;
  logic signed [NW-1:0] next_s;

  always_comb begin
    dec = '0;
    for (int k = 0; k < C_CLR_PORTS; k++) begin
      dec = dec + NW'(match_i[k]);
    end
    next_s      = $signed({{SB_CNT_GUARD_W{1'b0}}, count_q}) + $signed(NW'(inc_i)) - $signed(dec);
    // A flush wins over any clears landing the same cycle, so no underflow then.
    underflow_o = next_s[NW-1] & ~flush_i;
    if (flush_i || next_s[NW-1]) begin
      count_d = '0;
    end else begin
      count_d = C_PEND_W'(next_s);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (clk_en_i) begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign nonzero_o   = |count_q;
  assign saturated_o = (count_q == MAX_CNT);

endmodule

// File: rtl/load_scoreboard.sv
// rtl/load_scoreboard.sv - per-register pending-load scoreboard for the ID stage
// Decodes issue/clear addresses, forms the hazard stall and the pending view.

module load_scoreboard
  import load_scoreboard_pkg::*;
#(
  parameter int C_NREGS     = 32,
  parameter int C_PEND_W    = 2,
  parameter int C_CLR_PORTS = 2,
  parameter int C_AW        = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        clk_en_i,
  input  logic                        chk_valid_i,
  input  logic                        chk_rs1_rd_i,
  input  logic [C_AW-1:0]             chk_rs1_addr_i,
  input  logic                        chk_rs2_rd_i,
  input  logic [C_AW-1:0]             chk_rs2_addr_i,
  input  logic                        chk_rd_wr_i,
  input  logic                        chk_rd_load_i,
  input  logic [C_AW-1:0]             chk_rd_addr_i,
  input  logic                        issue_i,
  input  logic                        flush_i,
  input  logic [C_CLR_PORTS-1:0]      clr_valid_i,
  input  logic [C_CLR_PORTS*C_AW-1:0] clr_addr_i,
  output logic                        stall_o,
  output logic [C_NREGS-1:0]          pending_o,
  output logic                        busy_o,
  output logic                        underflow_o
);

  localparam int NA = 1 << C_AW;

  logic [C_NREGS-1:0]  nonzero;
  logic [C_NREGS-1:0]  saturated;
  logic [C_NREGS-1:0]  uf;
  logic [NA-1:0]       nz_all;
  logic [NA-1:0]       sat_all;
  logic [C_PEND_W-1:0] count_unused [C_NREGS];
  logic                underflow_q, underflow_d;

  // x0 has no counter; its slots read as empty and never saturated.
  assign nonzero[0]      = 1'b0;
  assign saturated[0]    = 1'b0;
  assign uf[0]           = 1'b0;
  assign count_unused[0] = '0;

  for (genvar r = 1; r < C_NREGS; r++) begin : g_cnt
    logic [C_CLR_PORTS-1:0] match;
    logic                   inc;

    for (genvar k = 0; k < C_CLR_PORTS; k++) begin : g_match
      assign match[k] = clr_valid_i[k] & (clr_addr_i[k*C_AW +: C_AW] == C_AW'(r));
    end

    assign inc = issue_i & chk_valid_i & chk_rd_load_i & ~stall_o & (chk_rd_addr_i == C_AW'(r));

    sb_counter #(
      .C_PEND_W    (C_PEND_W),
      .C_CLR_PORTS (C_CLR_PORTS)
    ) u_cnt (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .clk_en_i    (clk_en_i),
      .inc_i       (inc),
      .match_i     (match),
      .flush_i     (flush_i),
      .count_o     (count_unused[r]),
      .nonzero_o   (nonzero[r]),
      .saturated_o (saturated[r]),
      .underflow_o (uf[r])
    );
  end

  // Pad to the full address space so any C_AW-bit address indexes safely.
  assign nz_all  = NA'(nonzero);
  assign sat_all = NA'(saturated);

  assign stall_o = chk_valid_i &
                   ((chk_rs1_rd_i  & nz_all[chk_rs1_addr_i]) |
                    (chk_rs2_rd_i  & nz_all[chk_rs2_addr_i]) |
                    (chk_rd_wr_i   & nz_all[chk_rd_addr_i])  |
                    (chk_rd_load_i & sat_all[chk_rd_addr_i]));

  assign underflow_d = |uf;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      underflow_q <= 1'b0;
    end else if (clk_en_i) begin
      underflow_q <= underflow_d;
    end
  end

  assign pending_o   = nonzero;
  assign busy_o      = |nonzero;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_load_scoreboard.sv
// tb/tb_load_scoreboard.sv - self-checking bench for load_scoreboard
// Directed scenarios plus randomized traffic against a count-array model.

module tb_load_scoreboard;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NCLR  = 2;
  localparam int MAXP  = 3;

  logic            clk = 1'b0;
  logic            reset_i, clk_en_i, chk_valid_i;
  logic            chk_rs1_rd_i, chk_rs2_rd_i, chk_rd_wr_i, chk_rd_load_i;
  logic [AW-1:0]   chk_rs1_addr_i, chk_rs2_addr_i, chk_rd_addr_i;
  logic            issue_i, flush_i;
  logic [NCLR-1:0] clr_valid_i;
  logic [NCLR*AW-1:0] clr_addr_i;
  logic            stall_o, busy_o, underflow_o;
  logic [NREGS-1:0] pending_o;

  int  checks   = 0;
  int  failures = 0;
  bit  chk_on   = 0;
  int  cnt [NREGS];
  bit  m_uf;

  load_scoreboard dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .clk_en_i       (clk_en_i),
    .chk_valid_i    (chk_valid_i),
    .chk_rs1_rd_i   (chk_rs1_rd_i),
    .chk_rs1_addr_i (chk_rs1_addr_i),
    .chk_rs2_rd_i   (chk_rs2_rd_i),
    .chk_rs2_addr_i (chk_rs2_addr_i),
    .chk_rd_wr_i    (chk_rd_wr_i),
    .chk_rd_load_i  (chk_rd_load_i),
    .chk_rd_addr_i  (chk_rd_addr_i),
    .issue_i        (issue_i),
    .flush_i        (flush_i),
    .clr_valid_i    (clr_valid_i),
    .clr_addr_i     (clr_addr_i),
    .stall_o        (stall_o),
    .pending_o      (pending_o),
    .busy_o         (busy_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_stall();
    bit s;
    s = 0;
    if (chk_valid_i) begin
      if (chk_rs1_rd_i  && chk_rs1_addr_i != 0 && cnt[chk_rs1_addr_i] != 0)    s = 1;
      if (chk_rs2_rd_i  && chk_rs2_addr_i != 0 && cnt[chk_rs2_addr_i] != 0)    s = 1;
      if (chk_rd_wr_i   && chk_rd_addr_i  != 0 && cnt[chk_rd_addr_i]  != 0)    s = 1;
      if (chk_rd_load_i && chk_rd_addr_i  != 0 && cnt[chk_rd_addr_i]  == MAXP) s = 1;
    end
    return s;
  endfunction

  function automatic logic [NREGS-1:0] model_pending();
    logic [NREGS-1:0] v;
    v = '0;
    for (int r = 1; r < NREGS; r++) v[r] = (cnt[r] != 0);
    return v;
  endfunction

  always @(posedge clk) begin
    bit st;
    int n;
    st = model_stall();
    if (reset_i) begin
      for (int r = 0; r < NREGS; r++) cnt[r] = 0;
      m_uf = 0;
    end else if (clk_en_i) begin
      m_uf = 0;
      if (flush_i) begin
        for (int r = 0; r < NREGS; r++) cnt[r] = 0;
      end else begin
        for (int r = 1; r < NREGS; r++) begin
          n = cnt[r];
          if (issue_i && chk_valid_i && chk_rd_load_i && !st && chk_rd_addr_i == r) n++;
          for (int k = 0; k < NCLR; k++)
            if (clr_valid_i[k] && clr_addr_i[k*AW +: AW] == r) n--;
          if (n < 0) begin
            n = 0;
            m_uf = 1;
          end
          cnt[r] = n;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("stall",     {31'd0, stall_o},     {31'd0, model_stall()});
      chk("pending",   pending_o,            model_pending());
      chk("busy",      {31'd0, busy_o},      {31'd0, |model_pending()});
      chk("underflow", {31'd0, underflow_o}, {31'd0, m_uf});
    end
  end

  task automatic set_idle();
    reset_i = 0; clk_en_i = 1; chk_valid_i = 0;
    chk_rs1_rd_i = 0; chk_rs2_rd_i = 0; chk_rd_wr_i = 0; chk_rd_load_i = 0;
    chk_rs1_addr_i = '0; chk_rs2_addr_i = '0; chk_rd_addr_i = '0;
    issue_i = 0; flush_i = 0; clr_valid_i = '0; clr_addr_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int rd);
    chk_valid_i = 1; chk_rd_load_i = 1; chk_rd_addr_i = AW'(rd); issue_i = 1;
  endtask

  task automatic clr(input int port, input int addr);
    clr_valid_i[port] = 1;
    clr_addr_i[port*AW +: AW] = AW'(addr);
  endtask

  task automatic rand_inputs();
    reset_i        = ($urandom_range(0, 199) == 0);
    clk_en_i       = ($urandom_range(0, 9) != 0);
    flush_i        = ($urandom_range(0, 49) == 0);
    chk_valid_i    = ($urandom_range(0, 3) != 0);
    chk_rs1_rd_i   = 1'($urandom);
    chk_rs2_rd_i   = 1'($urandom);
    chk_rd_load_i  = 1'($urandom);
    chk_rd_wr_i    = !chk_rd_load_i && 1'($urandom);
    chk_rs1_addr_i = AW'($urandom_range(0, 7));
    chk_rs2_addr_i = AW'($urandom_range(0, 7));
    chk_rd_addr_i  = AW'($urandom_range(0, 7));
    issue_i        = ($urandom_range(0, 3) != 0);
    clr_valid_i    = ($urandom_range(0, 2) == 0) ? NCLR'($urandom) : '0;
    for (int k = 0; k < NCLR; k++) clr_addr_i[k*AW +: AW] = AW'($urandom_range(0, 7));
  endtask

  initial begin
    set_idle();
    reset_i = 1;
    step(); step();
    set_idle();
    chk_on = 1;

    // 1: idle after reset
    chk_valid_i = 1; chk_rs1_rd_i = 1; chk_rs1_addr_i = 5;
    #1;
    chk("t1_stall", {31'd0, stall_o}, 32'd0);
    chk("t1_pend", pending_o, 32'd0);
    chk("t1_busy", {31'd0, busy_o}, 32'd0);
    step();

    // 2: multiple loads to x5, then saturation
    set_idle(); load(5); step(); step();
    set_idle(); #1;
    chk("t2_pend5", {31'd0, pending_o[5]}, 32'd1);
    load(5); #1;
    chk("t2_third_stall", {31'd0, stall_o}, 32'd0);
    step();
    set_idle(); load(5); #1;
    chk("t2_fourth_stall", {31'd0, stall_o}, 32'd1);
    step();
    set_idle(); clr(0, 5); clr(1, 5); step();
    set_idle(); #1;
    chk("t2_after_two_clr", {31'd0, pending_o[5]}, 32'd1);
    clr(0, 5); step();
    set_idle(); #1;
    chk("t2_after_three_clr", {31'd0, pending_o[5]}, 32'd0);
    chk("t2_no_uf", {31'd0, underflow_o}, 32'd0);

    // 3: same-cycle clear does not release the stall
    load(7); step();
    set_idle(); chk_valid_i = 1; chk_rs2_rd_i = 1; chk_rs2_addr_i = 7; clr(1, 7); #1;
    chk("t3_stall_same", {31'd0, stall_o}, 32'd1);
    step();
    set_idle(); chk_valid_i = 1; chk_rs2_rd_i = 1; chk_rs2_addr_i = 7; #1;
    chk("t3_stall_next", {31'd0, stall_o}, 32'd0);
    chk("t3_pend7", {31'd0, pending_o[7]}, 32'd0);
    step();

    // 4: inc and dec cancel; double clear underflows
    set_idle(); load(3); step();
    set_idle(); load(3); clr(0, 3); step();
    set_idle(); #1;
    chk("t4_pend3", {31'd0, pending_o[3]}, 32'd1);
    clr(0, 3); clr(1, 3); step();
    set_idle(); #1;
    chk("t4_pend3_zero", {31'd0, pending_o[3]}, 32'd0);
    chk("t4_uf_pulse", {31'd0, underflow_o}, 32'd1);
    step();
    chk("t4_uf_drop", {31'd0, underflow_o}, 32'd0);

    // 5: flush beats a concurrent load
    load(4); step();
    set_idle(); load(9); step();
    set_idle(); load(12); step();
    set_idle(); #1;
    chk("t5_busy_before", {31'd0, busy_o}, 32'd1);
    flush_i = 1; load(4); clr(0, 20); step();
    set_idle(); #1;
    chk("t5_busy", {31'd0, busy_o}, 32'd0);
    chk("t5_pend", pending_o, 32'd0);
    chk("t5_uf", {31'd0, underflow_o}, 32'd0);

    // 6: x0 is ignored; clock enable freezes state
    load(0); chk_rs1_rd_i = 1; chk_rs1_addr_i = 0; clr(0, 0); #1;
    chk("t6_x0_stall", {31'd0, stall_o}, 32'd0);
    step();
    set_idle(); #1;
    chk("t6_x0_pend", pending_o, 32'd0);
    chk("t6_x0_uf", {31'd0, underflow_o}, 32'd0);
    clk_en_i = 0; load(6); step();
    set_idle(); #1;
    chk("t6_cken_pend", pending_o, 32'd0);
    chk("t6_cken_busy", {31'd0, busy_o}, 32'd0);

    // randomized traffic over a small address window to force collisions
    for (int i = 0; i < 4000; i++) begin
      rand_inputs();
      step();
    end
    set_idle();
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
